// File: rtl/digit_scanner_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment digit scanner.
`timescale 1ns/1ps
package digit_scanner_pkg;

   localparam int         DIGIT_W      = 4;
   localparam logic [3:0] BLANK_NIBBLE = 4'h0;

   // Width of a counter/index covering 0..n-1, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/digit_scanner_scan_timer.sv
// Slot counter and most-significant-first digit index for the digit scanner.
`timescale 1ns/1ps
module digit_scanner_scan_timer
   import digit_scanner_pkg::*;
#(
   parameter int NDIGITS = 4,
   parameter int DIV     = 12000,
   localparam int IW     = idx_w(NDIGITS),
   localparam int CW     = idx_w(DIV)
) (
   input  logic          clk,
   input  logic          resetn,
   output logic [CW-1:0] cnt,
   output logic [IW-1:0] idx,
   output logic          slot_end,
   output logic          frame_end
);

   assign slot_end  = (cnt == CW'(DIV - 1));
   assign frame_end = slot_end && (idx == '0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
         idx <= IW'(NDIGITS - 1);
      end else if (slot_end) begin
         cnt <= '0;
         idx <= frame_end ? IW'(NDIGITS - 1) : idx - 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/digit_scanner.sv
// Time-multiplexed digit scanner feeding a seven-segment decoder, with ripple-blanking chain.
// Optional feature: DIGIT_SCANNER_GHOST_BLANK_EN blanks enables for the first GHOST cycles of each slot.
`timescale 1ns/1ps
module digit_scanner
   import digit_scanner_pkg::*;
#(
   parameter int NDIGITS = 4,
   parameter int DIV     = 12000,
   parameter int GHOST   = 64
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [4*NDIGITS-1:0]     value,
   input  logic                     load,
   input  logic                     blank_lz,
   output logic [3:0]               data,
   output logic                     rbi,
   input  logic                     rbo,
   output logic [NDIGITS-1:0]       digit_en,
   output logic                     frame_start
);

   localparam int IW = idx_w(NDIGITS);
   localparam int CW = idx_w(DIV);

`ifdef DIGIT_SCANNER_GHOST_BLANK_EN
   localparam int GHOST_EFF = GHOST;
`else
   localparam int GHOST_EFF = 0;
`endif

   logic [CW-1:0]              cnt;
   logic [IW-1:0]              idx;
   logic                       slot_end;
   logic                       frame_end;
   logic [4*NDIGITS-1:0]       shadow;
   logic [4*NDIGITS-1:0]       pending;
   logic                       pend_v;
   logic                       chain;
   logic                       fs;
   logic                       settle;

   digit_scanner_scan_timer #(
      .NDIGITS (NDIGITS),
      .DIV     (DIV)
   ) u_timer (
      .clk       (clk),
      .resetn    (resetn),
      .cnt       (cnt),
      .idx       (idx),
      .slot_end  (slot_end),
      .frame_end (frame_end)
   );

   // A load on the boundary cycle itself bypasses pending and lands in shadow directly.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         shadow  <= '0;
         pending <= '0;
         pend_v  <= 1'b0;
         chain   <= 1'b0;
         fs      <= 1'b0;
      end else begin
         fs <= frame_end;
         if (load) begin
            pending <= value;
            pend_v  <= 1'b1;
         end
         if (frame_end) begin
            if (load)
               shadow <= value;
            else if (pend_v)
               shadow <= pending;
            pend_v <= 1'b0;
            chain  <= blank_lz;
         end else if (slot_end) begin
            chain <= rbo;
         end
      end
   end

   assign settle = (GHOST_EFF != 0) && (cnt < CW'(GHOST_EFF));

   always_comb begin
      data     = BLANK_NIBBLE;
      digit_en = '0;
      data     = shadow[DIGIT_W*idx +: DIGIT_W];
      if (!settle)
         digit_en = NDIGITS'(1) << idx;
   end

   // Least significant digit never blanks, so a zero value still shows "0".
   assign rbi         = (idx != '0) ? chain : 1'b0;
   assign frame_start = fs;

endmodule
